// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/freeze sequencing and X-stage forwarding selects; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_ctrl #(
    parameter int AW        = 5,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_D,
    input  logic [AW-1:0]    rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [AW-1:0]    rd_X,
    input  logic             regwen_X,
    input  logic             load_X,
    input  logic [AW-1:0]    rd_M,
    input  logic             regwen_M,
    input  logic [AW-1:0]    rd_W,
    input  logic             regwen_W,
    input  logic             redirect_X,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    output logic             nop,
    output logic             PCSel_f,
    output logic             freeze,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);
    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MEMWAIT} state_t;

    state_t        state, resume, cur, state_nx;
    logic [1:0]    cnt, cnt_nx;
    logic [AW-1:0] rs1_X, rs2_X;
    logic          load_use;

    // MEMWAIT is transparent: the interrupted state carries on once memory is ready
    assign cur      = (state == MEMWAIT) ? resume : state;
    assign load_use = load_X & regwen_X & (rd_X != '0) &
                      ((use_rs1_D & (rs1_D == rd_X)) | (use_rs2_D & (rs2_D == rd_X)));
    assign freeze   = reset & mem_req_M & ~mem_ready;
    assign fwdA     = (regwen_M && rd_M != '0 && rd_M == rs1_X) ? 2'd1 :
                      (regwen_W && rd_W != '0 && rd_W == rs1_X) ? 2'd2 : 2'd0;
    assign fwdB     = (regwen_M && rd_M != '0 && rd_M == rs2_X) ? 2'd1 :
                      (regwen_W && rd_W != '0 && rd_W == rs2_X) ? 2'd2 : 2'd0;

    // next state and strobes; a redirect squashes the dependent instruction, so it outranks load-use
    always_comb begin
        state_nx = cur;
        cnt_nx   = cnt;
        nop      = 1'b0;
        PCSel_f  = 1'b0;
        if (reset && !freeze) begin
            if (redirect_X) begin
                PCSel_f  = 1'b1;
                cnt_nx   = 2'(FLUSH_CYC - 1);
                state_nx = (FLUSH_CYC > 1) ? FLUSH : RUN;
            end else if (cur == FLUSH) begin
                PCSel_f  = 1'b1;
                cnt_nx   = cnt - 2'd1;
                state_nx = (cnt == 2'd1) ? RUN : FLUSH;
            end else if (cur == LDSTALL) begin
                state_nx = RUN;
            end else if (load_use) begin
                nop      = 1'b1;
                state_nx = LDSTALL;
            end
        end
    end

    // state, flush count and X-stage source registers; everything holds while frozen
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            resume <= RUN;
            cnt    <= 2'd0;
            rs1_X  <= '0;
            rs2_X  <= '0;
        end else if (freeze) begin
            state  <= MEMWAIT;
            resume <= cur;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rs1_X  <= (nop || PCSel_f) ? '0 : rs1_D;
            rs2_X  <= (nop || PCSel_f) ? '0 : rs2_D;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // saturating counts of bubble and squash cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (nop && perf_stall != '1) perf_stall <= perf_stall + CNT_W'(1);
            if (PCSel_f && perf_flush != '1) perf_flush <= perf_flush + CNT_W'(1);
        end
    end
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stalls, flushes, freezes and forwarding (FLUSH_CYC = 2)
module tb_hazard_ctrl;
    logic        clock = 1'b0, reset;
    logic [4:0]  rs1_D, rs2_D, rd_X, rd_M, rd_W;
    logic        use_rs1_D, use_rs2_D, regwen_X, load_X, regwen_M, regwen_W;
    logic        redirect_X, mem_req_M, mem_ready;
    logic        nop, PCSel_f, freeze;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] perf_stall, perf_flush;
    int          vectors = 0, miscompares = 0;

    hazard_ctrl #(.AW(5), .FLUSH_CYC(2), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_X(rd_X), .regwen_X(regwen_X),
        .load_X(load_X), .rd_M(rd_M), .regwen_M(regwen_M), .rd_W(rd_W), .regwen_W(regwen_W),
        .redirect_X(redirect_X), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .nop(nop), .PCSel_f(PCSel_f), .freeze(freeze), .fwdA(fwdA), .fwdB(fwdB),
        .perf_stall(perf_stall), .perf_flush(perf_flush));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {rs1_D, rs2_D, rd_X, rd_M, rd_W} = '0;
        {use_rs1_D, use_rs2_D, regwen_X, load_X, regwen_M, regwen_W} = '0;
        {redirect_X, mem_req_M, mem_ready} = '0;
    endtask

    task automatic ld_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        load_X = 1'b1; regwen_X = 1'b1; rd_X = rd;
        rs1_D = r1; rs2_D = r2; use_rs1_D = 1'b1; use_rs2_D = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #2;
        ld_use(5, 5, 7); redirect_X = 1; mem_req_M = 1; regwen_M = 1; rd_M = 5;
        #1;
        chk("rst_nop", nop, 0);
        chk("rst_pcsel", PCSel_f, 0);
        chk("rst_freeze", freeze, 0);
        chk("rst_fwdA", fwdA, 0);
        idle();
        @(negedge clock) reset = 1'b1;
        tick();
        chk("idle_nop", nop, 0);
        // lw x5 in X, add x6,x5,x7 in D
        ld_use(5, 5, 7);
        #1;
        chk("lu_nop", nop, 1);
        chk("lu_pcsel", PCSel_f, 0);
        tick();
        regwen_M = 1; rd_M = 5;
        #1;
        chk("lu_nop_once", nop, 0);
        chk("lu_bubble_fwdA", fwdA, 0);
        tick();
        idle(); rs1_D = 5; rs2_D = 7; regwen_W = 1; rd_W = 5;
        #1;
        chk("lu_fwdA_W", fwdA, 2);
        chk("lu_fwdB", fwdB, 0);
        // double match stalls once
        idle(); ld_use(9, 9, 9);
        #1;
        chk("dbl_nop", nop, 1);
        tick();
        #1;
        chk("dbl_nop_once", nop, 0);
        tick();
        ld_use(0, 0, 0);
        #1;
        chk("x0_no_stall", nop, 0);
        ld_use(5, 5, 5); use_rs1_D = 0; use_rs2_D = 0;
        #1;
        chk("unused_no_stall", nop, 0);
        // forwarding: add x5 in M, sub x8,x5,x5 in X
        idle(); rs1_D = 5; rs2_D = 5;
        tick();
        regwen_M = 1; rd_M = 5; regwen_W = 1; rd_W = 5;
        #1;
        chk("fwdA_M", fwdA, 1);
        chk("fwdB_M", fwdB, 1);
        rd_M = 0; regwen_W = 0;
        #1;
        chk("fwdA_x0", fwdA, 0);
        chk("fwdB_x0", fwdB, 0);
        regwen_W = 1;
        #1;
        chk("fwdB_W", fwdB, 2);
        regwen_M = 0; rd_M = 5; regwen_W = 0;
        #1;
        chk("fwdA_none", fwdA, 0);
        // redirect with simultaneous load-use
        idle(); ld_use(5, 5, 5); redirect_X = 1;
        #1;
        chk("rd_pcsel", PCSel_f, 1);
        chk("rd_no_nop", nop, 0);
        tick();
        redirect_X = 0;
        #1;
        chk("rd_pcsel2", PCSel_f, 1);
        chk("rd_no_nop2", nop, 0);
        tick();
        idle(); regwen_M = 1; rd_M = 5;
        #1;
        chk("rd_done", PCSel_f, 0);
        chk("rd_squash_fwdA", fwdA, 0);
        // redirect during flush restarts the count
        idle(); redirect_X = 1;
        tick();
        #1;
        chk("rs_pcsel_a", PCSel_f, 1);
        tick();
        redirect_X = 0;
        #1;
        chk("rs_pcsel_b", PCSel_f, 1);
        tick();
        chk("rs_done", PCSel_f, 0);
        // freeze in the middle of a flush
        redirect_X = 1;
        tick();
        redirect_X = 0; mem_req_M = 1;
        #1;
        chk("fz_1", freeze, 1);
        chk("fz_1_pcsel", PCSel_f, 0);
        tick();
        chk("fz_2", freeze, 1);
        tick();
        chk("fz_3", freeze, 1);
        tick();
        mem_ready = 1;
        #1;
        chk("fz_release", freeze, 0);
        chk("fz_resume_flush", PCSel_f, 1);
        tick();
        idle();
        #1;
        chk("fz_run", PCSel_f, 0);
        // freeze masks a load-use stall until memory is ready
        ld_use(3, 3, 4); mem_req_M = 1;
        #1;
        chk("fzlu_nop", nop, 0);
        chk("fzlu_freeze", freeze, 1);
        tick();
        mem_ready = 1;
        #1;
        chk("fzlu_nop_after", nop, 1);
        tick();
        idle();
        // asynchronous reset in the middle of a flush
        redirect_X = 1;
        tick();
        redirect_X = 0;
        #1;
        chk("rf_pcsel", PCSel_f, 1);
        reset = 1'b0;
        #1;
        chk("rf_pcsel_rst", PCSel_f, 0);
        chk("rf_nop_rst", nop, 0);
        chk("rf_freeze_rst", freeze, 0);
        #1 reset = 1'b1;
        tick();
        chk("rf_run", PCSel_f, 0);
        // counters: 4 load-use stalls then one redirect (2 squash cycles)
        for (int i = 0; i < 4; i++) begin
            ld_use(5'(i + 1), 5'(i + 1), 0);
            #1;
            chk("perf_nop", nop, 1);
            tick();
            idle();
            tick();
        end
        redirect_X = 1;
        tick();
        redirect_X = 0;
        tick();
        tick();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", perf_stall, 4);
        chk("perf_flush", perf_flush, 2);
`else
        chk("perf_stall_off", perf_stall, 0);
        chk("perf_flush_off", perf_flush, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
